sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//  Sequences an 8-bit-class serial-in/parallel-out shifter to receive framed serial words.
//  Counts qualified bits after a frame start and captures each completed word into an
//  output holding register. Presents that register over a valid/ready handshake.
//  Sits between a serial line front-end and any parallel word consumer.
// PARAMETERS
//  WIDTH  8                 data bits per frame (>=2)
//  CNT_W  $clog2(WIDTH+1)   bit-counter width (derived; do not override)
// PORTS
//  clk          in   1      single clock; all state on posedge
//  rst          in   1      asynchronous, active-LOW reset (0 = reset asserted)
//  sin          in   1      serial data bit
//  sin_valid    in   1      qualifies sin this cycle
//  frame_start  in   1      start of frame; restarts bit count
//  clr_err      in   1      clears sticky overrun
//  dout         out  WIDTH  received word; first-received bit at dout[WIDTH-1]
//  dout_valid   out  1      dout holds an unconsumed word
//  dout_ready   in   1      consumer accepts dout when dout_valid&&dout_ready
//  busy         out  1      frame in progress (state != IDLE)
//  overrun      out  1      sticky: a completed word was dropped
//  parity_err   out  1      parity status of the word on dout (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, count=0, shifter=0, dout=0, dout_valid=0,
//    overrun=0, parity_err=0. Reset mid-frame discards the partial word.
//  - States: IDLE -> SHIFT -> (PARITY) -> IDLE.
//  - IDLE: sin_valid without frame_start is ignored. frame_start -> SHIFT, count=0.
//  - frame_start with sin_valid in the same cycle: that bit is bit 0 of the new frame.
//  - SHIFT: each sin_valid shifts sin in at bit 0; older bits move toward the MSB. count++.
//  - frame_start in SHIFT/PARITY: partial frame is aborted. Count restarts per the rule
//    above. No word or error is produced.
//  - Completion: the edge that samples the WIDTH-th bit (or the parity bit) is edge N.
//    At edge N, dout <= {shifter[WIDTH-2:0], sin} (or the stored word), and dout_valid
//    is 1 after edge N. Zero extra latency.
//  - Holding register: dout_valid clears on a handshake. If completion coincides with a
//    handshake, the new word loads and dout_valid stays 1.
//  - Completion while dout_valid=1 and no handshake: the new word is dropped, dout is
//    unchanged, and overrun<=1. overrun clears only on clr_err; a same-cycle set wins.
//  - busy = (state != IDLE). Shifter and count hold when sin_valid=0.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//    - After WIDTH data bits, go to PARITY and wait for one more sin_valid bit
//      (even parity over data+parity).
//    - parity_err loads with dout: 1 if the XOR of all WIDTH+1 bits is 1.
//    - The word is delivered regardless of the parity result.
//  PARITY_CHECK_EN undefined:
//    - No PARITY state; the frame completes on the WIDTH-th bit.
//    - parity_err is tied 0; the port is still present.
// STRUCTURE
//  - Package sipo_ctrl_pkg: state enum (IDLE, SHIFT, PARITY) and state-encoding width.
//  - Sub-module sipo_shift_core: WIDTH-bit shift register with enable.
//    Ports: clk, rst, en, din, q.
//  - Controller FSM, counter, holding register and flags live in this module.
// TESTING
//  1. Reset, frame_start + bits 1,0,1,1,0,0,1,0 (WIDTH=8, no parity)
//     -> dout=8'hB2, dout_valid=1 after 8th bit edge.
//  2. Hold dout_ready=0, send two frames A5 then 3C -> dout stays A5, overrun=1;
//     clr_err -> overrun=0.
//  3. Word pending and ready=1 on same edge as next completion -> dout=new word, valid stays 1.
//  4. frame_start after 5 bits then 8 bits of 8'hFF -> dout=8'hFF, no partial word emitted.
//  5. rst=0 mid-frame after 3 bits, release, full frame 8'h01 -> dout=8'h01, busy low in reset.
//  6. PARITY_CHECK_EN: 8'h07 + parity 1 -> parity_err=0; 8'h07 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared state encoding for the framed serial-in/parallel-out receiver.
package sipo_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register: on en, din enters at bit 0 and older bits move toward the MSB.
module sipo_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shift_q;

    // Next shift value; holds when not enabled.
    always_comb begin
        shift_d = shift_q;
        if (en) begin
            shift_d = {shift_q[WIDTH-2:0], din};
        end else begin
            shift_d = shift_q;
        end
    end

    // Shift register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= {WIDTH{1'b0}};
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: bit counter FSM, output holding register and sticky flags.
// Optional even-parity bit after the data is enabled with PARITY_CHECK_EN.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             dout_valid_d, dout_valid_q;
    logic             overrun_d, overrun_q;
    logic [WIDTH-1:0] shift_q;
    logic             shift_en_s;
    logic             done_s;
    logic [WIDTH-1:0] word_s;
    logic             word_perr_s;
    logic             take_s;
    logic             drop_s;

`ifdef PARITY_CHECK_EN
    logic parity_err_d, parity_err_q;

    // Odd number of ones across data plus parity bit means the even-parity check failed.
    function automatic logic parity_fail(input logic [WIDTH-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`else
    logic shift_msb_unused_s;
    assign shift_msb_unused_s = shift_q[WIDTH-1];
`endif

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en_s),
        .din (sin),
        .q   (shift_q)
    );

    // Frame sequencing: a start always restarts the count, even mid-frame.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_en_s  = 1'b0;
        done_s      = 1'b0;
        word_s      = {WIDTH{1'b0}};
        word_perr_s = 1'b0;
        if (frame_start) begin
            state_d    = SHIFT;
            shift_en_s = sin_valid;
            count_d    = sin_valid ? CNT_ONE : {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (sin_valid) begin
                        shift_en_s = 1'b1;
                        if (count_q == LAST_CNT) begin
                            count_d = {CNT_W{1'b0}};
`ifdef PARITY_CHECK_EN
                            state_d = PARITY;
`else
                            done_s  = 1'b1;
                            word_s  = {shift_q[WIDTH-2:0], sin};
                            state_d = IDLE;
`endif
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    // Shifter is frozen here, so it still holds the complete data word.
                    if (sin_valid) begin
                        done_s      = 1'b1;
                        word_s      = shift_q;
                        word_perr_s = parity_fail(shift_q, sin);
                        state_d     = IDLE;
                    end else begin
                        state_d = PARITY;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    count_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Holding register: a completion may reuse the slot freed by a same-cycle handshake.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        take_s       = dout_valid_q && dout_ready;
        drop_s       = 1'b0;
        if (done_s) begin
            if (!dout_valid_q || take_s) begin
                dout_d       = word_s;
                dout_valid_d = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (take_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Controller and output state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= {CNT_W{1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity status travels with the word it describes.
    always_comb begin
        parity_err_d = parity_err_q;
        if (done_s && (!dout_valid_q || take_s)) begin
            parity_err_d = word_perr_s;
        end else begin
            parity_err_d = parity_err_q;
        end
    end

    // Parity status register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl (WIDTH=8).
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       frame_start;
    logic       clr_err;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int total;
    int bad;

    sipo_frame_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .clr_err     (clr_err),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic start_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Final data bit, plus the even-parity bit when that feature is built in.
    task automatic last_bits(input logic b, input logic [7:0] w);
        send_bit(b);
`ifdef PARITY_CHECK_EN
        send_bit(^w);
`endif
    endtask

    task automatic send_frame(input logic [7:0] w);
        start_pulse();
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        last_bits(w[0], w);
    endtask

    task automatic consume();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        total = 0;
        bad   = 0;
        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
        clr_err = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        rst = 1'b1;
        tick();

        // 1: basic frame 8'hB2, zero-latency completion
        w = 8'hB2;
        start_pulse();
        chk("t1_busy", busy, 1'b1);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("t1_valid_early", dout_valid, 1'b0);
        last_bits(w[0], w);
        chk("t1_dout", dout, 8'hB2);
        chk("t1_valid", dout_valid, 1'b1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_perr", parity_err, 1'b0);
        consume();
        chk("t1_consumed", dout_valid, 1'b0);

        // IDLE ignores sin_valid without frame_start
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        chk("idle_valid", dout_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_dout", dout, 8'hB2);

        // 2: overrun on dropped word, set beats clear, clr_err clears
        send_frame(8'hA5);
        chk("t2_first", dout, 8'hA5);
        send_frame(8'h3C);
        chk("t2_hold", dout, 8'hA5);
        chk("t2_valid", dout_valid, 1'b1);
        chk("t2_overrun", overrun, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2_clr", overrun, 1'b0);
        w = 8'h5A;
        start_pulse();
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        clr_err = 1'b1;
        last_bits(w[0], w);
        clr_err = 1'b0;
        chk("t2_set_wins", overrun, 1'b1);
        chk("t2_hold2", dout, 8'hA5);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2_clr2", overrun, 1'b0);
        consume();

        // 3: completion coincides with handshake
        send_frame(8'h11);
        chk("t3_first", dout, 8'h11);
        w = 8'h22;
        start_pulse();
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        dout_ready = 1'b1;
        last_bits(w[0], w);
        dout_ready = 1'b0;
        chk("t3_dout", dout, 8'h22);
        chk("t3_valid", dout_valid, 1'b1);
        chk("t3_overrun", overrun, 1'b0);
        consume();
        chk("t3_consumed", dout_valid, 1'b0);

        // 4: abort after 5 bits; restart with a bit in the same cycle
        start_pulse();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        frame_start = 1'b1;
        send_bit(1'b1);
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        chk("t4_no_partial", dout_valid, 1'b0);
        chk("t4_busy", busy, 1'b1);
        last_bits(1'b1, 8'hFF);
        chk("t4_dout", dout, 8'hFF);
        chk("t4_valid", dout_valid, 1'b1);
        chk("t4_overrun", overrun, 1'b0);
        consume();

        // 5: async reset mid-frame
        start_pulse();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b0;
        #2;
        chk("t5_busy_rst", busy, 1'b0);
        chk("t5_dout_rst", dout, 8'h00);
        chk("t5_valid_rst", dout_valid, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        send_frame(8'h01);
        chk("t5_dout", dout, 8'h01);
        chk("t5_valid", dout_valid, 1'b1);
        consume();

`ifdef PARITY_CHECK_EN
        // 6: parity good then bad
        w = 8'h07;
        start_pulse();
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        chk("t6_wait_par", dout_valid, 1'b0);
        chk("t6_busy_par", busy, 1'b1);
        send_bit(1'b1);
        chk("t6_dout_ok", dout, 8'h07);
        chk("t6_perr_ok", parity_err, 1'b0);
        consume();
        start_pulse();
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        send_bit(1'b0);
        chk("t6_dout_bad", dout, 8'h07);
        chk("t6_valid_bad", dout_valid, 1'b1);
        chk("t6_perr_bad", parity_err, 1'b1);
        consume();
`else
        chk("t6_perr_tied", parity_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
